dmem_stage: RTL and testbench

Data-memory stage of the pipelined RISC-V core. It sits downstream of the execute stage and upstream of write-back. It performs byte, halfword and word loads and stores on a little-endian byte array. Load data is delivered through a registered MEM/WB output with sign or zero extension. Misaligned, out-of-range and illegal accesses are reported as faults.

---
 rtl/riscv_pkg.sv | 24 ++
 rtl/load_extend.sv | 27 ++
 rtl/dmem_stage.sv | 117 +++++++++++
 tb/tb_dmem_stage.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared RV32I load/store definitions: funct3 access encodings and access size helper.
package riscv_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   // Undefined encodings report 4; callers reject them separately.
   function automatic logic [2:0] size_bytes(input logic [2:0] funct3);
      case (funct3)
         F3_B, F3_BU: size_bytes = 3'd1;
         F3_H, F3_HU: size_bytes = 3'd2;
         default:     size_bytes = 3'd4;
      endcase
   endfunction

   function automatic logic funct3_defined(input logic [2:0] funct3);
      funct3_defined = (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W) ||
                       (funct3 == F3_BU) || (funct3 == F3_HU);
   endfunction

endpackage

// File: rtl/load_extend.sv
// Picks the addressed byte/halfword out of a little-endian word and sign- or zero-extends it.
module load_extend
   import riscv_pkg::*;
(
   input  logic [2:0]  funct3_i,
   input  logic [1:0]  off_i,
   input  logic [31:0] word_i,
   output logic [31:0] data_o
);

   logic [31:0] shifted;

   assign shifted = word_i >> {off_i, 3'b000};

   always_comb begin
      data_o = '0;
      case (funct3_i)
         F3_B:    data_o = {{24{shifted[7]}}, shifted[7:0]};
         F3_H:    data_o = {{16{shifted[15]}}, shifted[15:0]};
         F3_W:    data_o = word_i;
         F3_BU:   data_o = {24'd0, shifted[7:0]};
         F3_HU:   data_o = {16'd0, shifted[15:0]};
         default: data_o = '0;
      endcase
   end

endmodule

// File: rtl/dmem_stage.sv
// Data-memory pipeline stage: byte-addressed little-endian array with registered,
// extended load results and one-cycle fault pulses for rejected accesses.
module dmem_stage
   import riscv_pkg::*;
#(
   parameter int MEM_SIZE = 256,
   parameter int ADDR_W   = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              valid_i,
   input  logic              re_i,
   input  logic              we_i,
   input  logic [2:0]        funct3_i,
   input  logic [ADDR_W-1:0] addr_i,
   input  logic [31:0]       wdata_i,
   input  logic              stall_i,
   output logic [31:0]       rdata_o,
   output logic              rvalid_o,
   output logic              fault_o
);

   localparam int IDX_W = $clog2(MEM_SIZE);

   // Handshake: an access is taken on any edge where valid_i=1, stall_i=0 and
   // re_i|we_i; its result (rvalid_o or fault_o) is visible right after that edge.
   // stall_i freezes every register including the outputs.

   logic [7:0]        mem [0:MEM_SIZE-1];
   logic [31:0]       rdata_q, rdata_d;
   logic              rvalid_q, rvalid_d;
   logic              fault_q, fault_d;

   logic              active;
   logic [2:0]        size;
   logic              bad_op, misaligned, out_of_range, fault;
   logic              store_en;
   logic [ADDR_W:0]   last_byte;
   logic [IDX_W-1:0]  idx, base;
   logic [31:0]       word;
   logic [31:0]       load_data;

   assign active = valid_i && (re_i || we_i);
   assign size   = size_bytes(funct3_i);

   assign bad_op       = !funct3_defined(funct3_i) ||
                         (we_i && ((funct3_i == F3_BU) || (funct3_i == F3_HU)));
   assign misaligned   = ((size == 3'd2) && addr_i[0]) ||
                         ((size == 3'd4) && (addr_i[1:0] != 2'b00));
   // One extra bit so an address near the top of the space cannot wrap into range.
   assign last_byte    = {1'b0, addr_i} + (ADDR_W+1)'(size) - (ADDR_W+1)'(1);
   assign out_of_range = last_byte >= (ADDR_W+1)'(MEM_SIZE);
   assign fault        = bad_op || misaligned || out_of_range;

   assign store_en = active && !stall_i && we_i && !fault;

   assign idx  = addr_i[IDX_W-1:0];
   assign base = idx & ~IDX_W'(3);
   assign word = {mem[base + IDX_W'(3)], mem[base + IDX_W'(2)],
                  mem[base + IDX_W'(1)], mem[base]};

   load_extend u_load_extend (
      .funct3_i (funct3_i),
      .off_i    (addr_i[1:0]),
      .word_i   (word),
      .data_o   (load_data)
   );

   always_comb begin
      rdata_d  = rdata_q;
      rvalid_d = rvalid_q;
      fault_d  = fault_q;
      if (!stall_i) begin
         if (active) begin
            if (fault) begin
               rdata_d  = '0;
               rvalid_d = 1'b0;
               fault_d  = 1'b1;
            end else if (we_i) begin
               rdata_d  = '0;
               rvalid_d = 1'b0;
               fault_d  = 1'b0;
            end else begin
               rdata_d  = load_data;
               rvalid_d = 1'b1;
               fault_d  = 1'b0;
            end
         end else begin
            rvalid_d = 1'b0;
            fault_d  = 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int i = 0; i < MEM_SIZE; i++) mem[i] <= 8'h00;
         rdata_q  <= '0;
         rvalid_q <= 1'b0;
         fault_q  <= 1'b0;
      end else begin
         rdata_q  <= rdata_d;
         rvalid_q <= rvalid_d;
         fault_q  <= fault_d;
         if (store_en) begin
            for (int i = 0; i < 4; i++) begin
               if (3'(i) < size) mem[idx + IDX_W'(i)] <= wdata_i[8*i +: 8];
            end
         end
      end
   end

   assign rdata_o  = rdata_q;
   assign rvalid_o = rvalid_q;
   assign fault_o  = fault_q;

endmodule

// File: tb/tb_dmem_stage.sv
// Scoreboard bench for dmem_stage: a byte-array reference model predicts each cycle's
// outputs, a monitor compares them after every edge, and memory is probed directly.
module tb_dmem_stage;

   localparam int MEM_SIZE = 256;
   localparam int ADDR_W   = 32;

   logic        clk;
   logic        rst;
   logic        valid_i, re_i, we_i, stall_i;
   logic [2:0]  funct3_i;
   logic [31:0] addr_i, wdata_i;
   logic [31:0] rdata_o;
   logic        rvalid_o, fault_o;

   int checks   = 0;
   int failures = 0;
   int cycle_no = 0;

   logic [33:0] exp_q[$];          // {rvalid, fault, rdata}
   logic [7:0]  mem_m [0:MEM_SIZE-1];
   logic [31:0] m_rdata;
   logic        m_rvalid, m_fault;

   dmem_stage #(.MEM_SIZE(MEM_SIZE), .ADDR_W(ADDR_W)) dut (
      .clk      (clk),
      .rst      (rst),
      .valid_i  (valid_i),
      .re_i     (re_i),
      .we_i     (we_i),
      .funct3_i (funct3_i),
      .addr_i   (addr_i),
      .wdata_i  (wdata_i),
      .stall_i  (stall_i),
      .rdata_o  (rdata_o),
      .rvalid_o (rvalid_o),
      .fault_o  (fault_o)
   );

   // ---------------- clock ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   task automatic model_step(input logic v, input logic r, input logic w, input logic [2:0] f3,
                             input logic [31:0] a, input logic [31:0] d, input logic s,
                             input logic rn);
      int     sz;
      logic   flt;
      longint val;
      if (!rn) begin
         for (int k = 0; k < MEM_SIZE; k++) mem_m[k] = 8'h00;
         m_rdata = 0; m_rvalid = 0; m_fault = 0;
      end else if (!s) begin
         if (v && (r || w)) begin
            if (f3 == 3'd0 || f3 == 3'd4)      sz = 1;
            else if (f3 == 3'd1 || f3 == 3'd5) sz = 2;
            else                               sz = 4;
            flt = (f3 == 3'd3) || (f3 >= 3'd6) || (w && (f3 == 3'd4 || f3 == 3'd5)) ||
                  ((longint'(a) % sz) != 0) || (longint'(a) + sz - 1 >= MEM_SIZE);
            if (flt) begin
               m_rdata = 0; m_rvalid = 0; m_fault = 1;
            end else if (w) begin
               for (int k = 0; k < sz; k++) mem_m[int'(a) + k] = 8'((d >> (8 * k)) & 32'hFF);
               m_rdata = 0; m_rvalid = 0; m_fault = 0;
            end else begin
               val = 0;
               for (int k = 0; k < sz; k++) val = val + (longint'(mem_m[int'(a) + k]) << (8 * k));
               if (f3 == 3'd0 && val >= 128)   val = val - 256;
               if (f3 == 3'd1 && val >= 32768) val = val - 65536;
               m_rdata = 32'(val); m_rvalid = 1; m_fault = 0;
            end
         end else begin
            m_rvalid = 0; m_fault = 0;
         end
      end
   endtask

   // ---------------- driver ----------------
   task automatic drive(input logic v, input logic r, input logic w, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] d, input logic s,
                        input logic rn);
      valid_i = v; re_i = r; we_i = w; funct3_i = f3; addr_i = a; wdata_i = d;
      stall_i = s; rst = rn;
      model_step(v, r, w, f3, a, d, s, rn);
      exp_q.push_back({m_rvalid, m_fault, m_rdata});
      @(posedge clk);
      #2;
   endtask

   task automatic st(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
      drive(1, 0, 1, f3, a, d, 0, 1);
   endtask

   task automatic ld(input logic [2:0] f3, input logic [31:0] a);
      drive(1, 1, 0, f3, a, 32'h0, 0, 1);
   endtask

   task automatic idle();
      drive(0, 0, 0, 3'd0, 32'h0, 32'h0, 0, 1);
   endtask

   task automatic check_byte(input string name, input int a, input logic [7:0] req);
      checks++;
      if (dut.mem[a] !== req) begin
         failures++;
         $display("FAIL %s mem[%0d] got=%02h want=%02h", name, a, dut.mem[a], req);
      end
   endtask

   // ---------------- monitor / scoreboard ----------------
   initial begin
      logic [33:0] e;
      forever begin
         @(posedge clk);
         #1;
         cycle_no++;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if ({rvalid_o, fault_o, rdata_o} !== e) begin
               failures++;
               $display("FAIL out cycle=%0d got rvalid=%0b fault=%0b rdata=%08h want rvalid=%0b fault=%0b rdata=%08h",
                        cycle_no, rvalid_o, fault_o, rdata_o, e[33], e[32], e[31:0]);
            end
         end
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      int          mode;
      logic [31:0] a;
      logic [2:0]  f3;
      valid_i = 0; re_i = 0; we_i = 0; stall_i = 0; funct3_i = 0; addr_i = 0; wdata_i = 0;
      rst = 0;

      // reset
      drive(0, 0, 0, 3'd0, 32'h0, 32'h0, 0, 0);
      drive(0, 0, 0, 3'd0, 32'h0, 32'h0, 0, 0);
      check_byte("reset", 8, 8'h00);

      // store word then load it back
      st(3'b010, 32'd8, 32'h0F0F0F0F);
      for (int k = 8; k < 12; k++) check_byte("sw8", k, 8'h0F);
      ld(3'b010, 32'd8);
      idle();

      // halfword store and the four extending loads
      st(3'b001, 32'd20, 32'h1234FFFE);
      check_byte("sh20_lo", 20, 8'hFE);
      check_byte("sh20_hi", 21, 8'hFF);
      ld(3'b001, 32'd20);
      ld(3'b101, 32'd20);
      ld(3'b000, 32'd21);
      ld(3'b100, 32'd20);

      // faulting accesses, including a wrapping address
      st(3'b010, 32'd22, 32'hAAAAAAAA);
      st(3'b001, 32'd21, 32'hBBBB);
      ld(3'b010, MEM_SIZE - 2);
      ld(3'b010, 32'hFFFF_FFFC);
      st(3'b100, 32'd24, 32'h11);
      ld(3'b011, 32'd0);
      check_byte("nowrite22", 22, 8'h00);
      check_byte("nowrite21", 21, 8'hFF);

      // boundary loads that stay in range
      ld(3'b010, MEM_SIZE - 4);
      ld(3'b100, MEM_SIZE - 1);
      ld(3'b001, MEM_SIZE - 2);

      // read-after-write
      st(3'b000, 32'd22, 32'hFFFFFF01);
      ld(3'b100, 32'd22);

      // stall holds everything, a stalled store writes nothing
      ld(3'b010, 32'd8);
      drive(1, 1, 0, 3'b010, 32'd20, 32'h0, 1, 1);
      drive(1, 1, 0, 3'b010, 32'd20, 32'h0, 1, 1);
      drive(1, 0, 1, 3'b010, 32'd8, 32'h55555555, 1, 1);
      check_byte("stall_nowrite", 8, 8'h0F);
      ld(3'b010, 32'd20);

      // store and load together: store wins
      drive(1, 1, 1, 3'b010, 32'd4, 32'h01020304, 0, 1);
      check_byte("rw_store", 4, 8'h04);

      // reset in the same cycle as a store
      drive(1, 0, 1, 3'b010, 32'd4, 32'hDEADBEEF, 0, 0);
      for (int k = 4; k < 8; k++) check_byte("rst_drop", k, 8'h00);
      idle();

      // randomized traffic
      for (int n = 0; n < 400; n++) begin
         mode = $urandom_range(0, 9);
         if (mode < 8) a = $urandom_range(0, MEM_SIZE + 7);
         else if (mode == 8) a = 32'hFFFF_FFFC + $urandom_range(0, 3);
         else a = $urandom;
         if ($urandom_range(0, 1) == 1) a = a & ~32'h3;
         f3 = ($urandom_range(0, 4) == 0) ? 3'($urandom_range(0, 7))
                                          : 3'($urandom_range(0, 2));
         if ($urandom_range(0, 2) == 0 && f3 < 3'd2) f3 = f3 | 3'b100;
         drive($urandom_range(0, 7) != 0, $urandom_range(0, 1) == 1, $urandom_range(0, 2) == 0,
               f3, a, $urandom, $urandom_range(0, 9) == 0, $urandom_range(0, 59) != 0);
      end
      idle();
      idle();

      // whole-array comparison against the model
      for (int k = 0; k < MEM_SIZE; k++) check_byte("final_mem", k, mem_m[k]);

      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL drain got=%0d want=0", exp_q.size());
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout got=running want=finished");
      $fatal(1, "timeout");
   end

endmodule
